// File: rtl/day_display_sequencer.sv
// Day-of-week letter display controller: holds the current day, advances it on a
// prescaled tick, step or load, and scans its three-letter abbreviation onto a
// shared 3-digit display.
//
// state | meaning
// MON   | day 0, letters M O N
// TUE   | day 1, letters T U E
// WED   | day 2, letters W E D
// THU   | day 3, letters T H U
// FRI   | day 4, letters F R I
// SAT   | day 5, letters S A T
// SUN   | day 6, letters S U N
module day_display_sequencer #(
    parameter int DAY_TICKS  = 3,
    parameter int SCAN_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
    input  logic       load,
    input  logic [2:0] load_day,
    output logic [2:0] day,
    output logic       day_tick,
    output logic [2:0] digit_en_n,
    output logic [3:0] letter
);

    typedef enum logic [2:0] {
        MON = 3'd0,
        TUE = 3'd1,
        WED = 3'd2,
        THU = 3'd3,
        FRI = 3'd4,
        SAT = 3'd5,
        SUN = 3'd6
    } day_t;

    localparam logic [7:0] DAY_LAST  = 8'(DAY_TICKS - 1);
    localparam logic [7:0] SCAN_LAST = 8'(SCAN_TICKS - 1);
    localparam logic [3:0] BLANK     = 4'd15;

    day_t       day_q;
    logic [7:0] presc;
    logic [7:0] scan_cnt;
    logic [1:0] digit;

    function automatic day_t next_day(input day_t d);
        if (d == SUN) return MON;
        return day_t'(d + 3'd1);
    endfunction

    // Day state machine with prescaler; load beats step beats auto-advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_q    <= MON;
            presc    <= 8'd0;
            day_tick <= 1'b0;
        end else if (load) begin
            day_q    <= (load_day == 3'd7) ? MON : day_t'(load_day);
            presc    <= 8'd0;
            day_tick <= 1'b1;
        end else if (step) begin
            day_q    <= next_day(day_q);
            presc    <= 8'd0;
            day_tick <= 1'b1;
        end else if (run && presc == DAY_LAST) begin
            day_q    <= next_day(day_q);
            presc    <= 8'd0;
            day_tick <= 1'b1;
        end else if (run) begin
            presc    <= presc + 8'd1;
            day_tick <= 1'b0;
        end else begin
            day_tick <= 1'b0;
        end
    end

    // Free-running digit scan, unaffected by run/step/load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= 8'd0;
            digit    <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= 8'd0;
            digit    <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 8'd1;
        end
    end

    assign day = day_q;

    // Digit enable decode; bit0 is the leftmost letter.
    always_comb begin
        case (digit)
            2'd0:    digit_en_n = 3'b110;
            2'd1:    digit_en_n = 3'b101;
            2'd2:    digit_en_n = 3'b011;
            default: digit_en_n = 3'b111;
        endcase
    end

    // Letter decode of (day, digit); rightmost letter blanks while on hold.
    always_comb begin
        letter = BLANK;
        case ({day_q, digit})
            {MON, 2'd0}: letter = 4'd0;
            {MON, 2'd1}: letter = 4'd1;
            {MON, 2'd2}: letter = 4'd2;
            {TUE, 2'd0}: letter = 4'd3;
            {TUE, 2'd1}: letter = 4'd4;
            {TUE, 2'd2}: letter = 4'd5;
            {WED, 2'd0}: letter = 4'd6;
            {WED, 2'd1}: letter = 4'd5;
            {WED, 2'd2}: letter = 4'd7;
            {THU, 2'd0}: letter = 4'd3;
            {THU, 2'd1}: letter = 4'd8;
            {THU, 2'd2}: letter = 4'd4;
            {FRI, 2'd0}: letter = 4'd9;
            {FRI, 2'd1}: letter = 4'd10;
            {FRI, 2'd2}: letter = 4'd11;
            {SAT, 2'd0}: letter = 4'd12;
            {SAT, 2'd1}: letter = 4'd13;
            {SAT, 2'd2}: letter = 4'd3;
            {SUN, 2'd0}: letter = 4'd12;
            {SUN, 2'd1}: letter = 4'd4;
            {SUN, 2'd2}: letter = 4'd2;
            default:     letter = BLANK;
        endcase
        if (!run && digit == 2'd2) letter = BLANK;
    end

endmodule
